// File: rtl/spot_allocator.sv
// Parking-lot spot allocator: tracks per-spot occupancy, grants the
// lowest free spot to the entry gate and releases spots from the exit gate.
module spot_allocator #(
    parameter int unsigned N_SPOTS = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enter_req,
    output logic               enter_gnt,
    output logic               enter_deny,
    output logic [IDX_W-1:0]   assigned_spot,
    input  logic               exit_valid,
    input  logic [IDX_W-1:0]   exit_spot,
    output logic               exit_err,
    output logic [N_SPOTS-1:0] capacity,
    output logic [CNT_W-1:0]   parked_count,
    output logic               full,
    output logic               empty
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_REL = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [N_SPOTS-1:0] exit_mask;
    logic [N_SPOTS-1:0] avail;
    logic [N_SPOTS-1:0] grant_mask;
    logic [N_SPOTS-1:0] capacity_next;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   spot_next;
    logic [CNT_W-1:0]   count_next;
    logic               exit_legal;
    logic               any_free;
    logic               grant_c;
    logic               deny_c;
    logic               err_c;

    // Exit decode; an out-of-range index matches no bit and so is never legal.
    always_comb begin
        exit_mask = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (exit_valid && (exit_spot == IDX_W'(i)) && capacity[i]) begin
                exit_mask[i] = 1'b1;
            end
        end
        exit_legal = |exit_mask;
        err_c      = exit_valid && !exit_legal;
    end

    // Lowest free spot, counting a spot released this cycle as free.
    always_comb begin
        avail    = capacity & ~exit_mask;
        pick_idx = '0;
        any_free = 1'b0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (!any_free && !avail[i]) begin
                pick_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    // Entry handshake next-state and next-value logic.
    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        deny_c     = 1'b0;
        case (state)
            IDLE: begin
                if (enter_req) begin
                    grant_c    = any_free;
                    deny_c     = !any_free;
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!enter_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        grant_mask    = grant_c ? (N_SPOTS'(1) << pick_idx) : '0;
        capacity_next = avail | grant_mask;
        count_next    = parked_count + CNT_W'(grant_c) - CNT_W'(exit_legal);
        spot_next     = grant_c ? pick_idx : assigned_spot;
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs; flags follow the next count so they match capacity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_gnt     <= 1'b0;
            enter_deny    <= 1'b0;
            exit_err      <= 1'b0;
            assigned_spot <= '0;
            capacity      <= '0;
            parked_count  <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
        end else begin
            enter_gnt     <= grant_c;
            enter_deny    <= deny_c;
            exit_err      <= err_c;
            assigned_spot <= spot_next;
            capacity      <= capacity_next;
            parked_count  <= count_next;
            full          <= (count_next == CNT_W'(N_SPOTS));
            empty         <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_spot_allocator.sv
// Self-checking bench for spot_allocator: directed scenarios plus random
// gate traffic, all compared against a per-spot occupancy model.
module tb_spot_allocator;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enter_req;
    logic       enter_gnt;
    logic       enter_deny;
    logic [2:0] assigned_spot;
    logic       exit_valid;
    logic [2:0] exit_spot;
    logic       exit_err;
    logic [7:0] capacity;
    logic [3:0] parked_count;
    logic       full;
    logic       empty;

    int checks   = 0;
    int failures = 0;

    // Reference model: one flag per spot, a "request already answered" flag,
    // the last granted spot and the pulses expected after the coming edge.
    bit m_occ [N];
    bit m_busy;
    int m_spot;
    bit e_gnt;
    bit e_deny;
    bit e_err;

    spot_allocator #(.N_SPOTS(8), .IDX_W(3), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enter_req    (enter_req),
        .enter_gnt    (enter_gnt),
        .enter_deny   (enter_deny),
        .assigned_spot(assigned_spot),
        .exit_valid   (exit_valid),
        .exit_spot    (exit_spot),
        .exit_err     (exit_err),
        .capacity     (capacity),
        .parked_count (parked_count),
        .full         (full),
        .empty        (empty)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] occ_vec();
        logic [7:0] v;
        for (int i = 0; i < N; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic int occ_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
        m_busy = 1'b0;
        m_spot = 0;
        e_gnt  = 1'b0;
        e_deny = 1'b0;
        e_err  = 1'b0;
    endtask

    task automatic check_all();
        chk("enter_gnt",     32'(enter_gnt),     32'(e_gnt));
        chk("enter_deny",    32'(enter_deny),    32'(e_deny));
        chk("exit_err",      32'(exit_err),      32'(e_err));
        chk("capacity",      32'(capacity),      32'(occ_vec()));
        chk("parked_count",  32'(parked_count),  32'(occ_count()));
        chk("full",          32'(full),          32'(occ_count() == N));
        chk("empty",         32'(empty),         32'(occ_count() == 0));
        chk("assigned_spot", 32'(assigned_spot), 32'(m_spot));
        chk("count_vs_ones", 32'(parked_count),  32'($countones(capacity)));
    endtask

    // One clock of stimulus: drive at the falling edge, predict, check after the rising edge.
    task automatic step(input bit req, input bit ev, input int es);
        bit legal;
        bit nxt [N];
        int pick;
        @(negedge clk);
        enter_req  = req;
        exit_valid = ev;
        exit_spot  = 3'(es);
        legal = ev && (es < N) && m_occ[es];
        nxt   = m_occ;
        if (legal) nxt[es] = 1'b0;
        e_gnt  = 1'b0;
        e_deny = 1'b0;
        e_err  = ev && !legal;
        if (!m_busy && req) begin
            pick = -1;
            for (int i = N - 1; i >= 0; i--) if (!nxt[i]) pick = i;
            if (pick >= 0) begin
                e_gnt     = 1'b1;
                m_spot    = pick;
                nxt[pick] = 1'b1;
            end else begin
                e_deny = 1'b1;
            end
            m_busy = 1'b1;
        end else if (m_busy && !req) begin
            m_busy = 1'b0;
        end
        m_occ = nxt;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic enter_car();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
    endtask

    initial begin
        bit req;
        rst_n      = 1'b0;
        enter_req  = 1'b0;
        exit_valid = 1'b0;
        exit_spot  = 3'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the lot in index order.
        for (int k = 0; k < N; k++) enter_car();
        chk("fill_capacity", 32'(capacity), 32'h0000_00FF);
        chk("fill_count",    32'(parked_count), 32'd8);
        chk("fill_full",     32'(full), 32'd1);

        // Full lot: single deny for a held request.
        step(1'b1, 1'b0, 0);
        chk("deny_pulse", 32'(enter_deny), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Release and request in the same cycle while full.
        step(1'b1, 1'b1, 3);
        chk("swap_gnt",  32'(enter_gnt), 32'd1);
        chk("swap_spot", 32'(assigned_spot), 32'd3);
        chk("swap_cap",  32'(capacity), 32'h0000_00FF);
        step(1'b0, 1'b0, 0);

        // Shrink to 0000_0101, then an illegal and a legal exit.
        step(1'b0, 1'b1, 1);
        for (int k = 3; k < N; k++) step(1'b0, 1'b1, k);
        chk("cap_0101", 32'(capacity), 32'h0000_0005);
        step(1'b0, 1'b1, 1);
        chk("err_pulse", 32'(exit_err), 32'd1);
        step(1'b0, 1'b1, 2);
        chk("cap_0001", 32'(capacity), 32'h0000_0001);

        // Build 0000_1011, grant fills the hole at 2, held request gets nothing more.
        for (int k = 0; k < 3; k++) enter_car();
        step(1'b0, 1'b1, 2);
        chk("cap_1011", 32'(capacity), 32'h0000_000B);
        step(1'b1, 1'b0, 0);
        chk("hole_spot", 32'(assigned_spot), 32'd2);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Random gate traffic.
        req = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) req = !req;
            step(req, ($urandom_range(0, 2) == 0), int'($urandom_range(0, N - 1)));
        end
        step(1'b0, 1'b0, 0);

        // Asynchronous reset between request and the edge that would grant it.
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        enter_req = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        enter_req = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        enter_car();
        enter_car();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
